// File: rtl/kcc_pkg.sv
// Shared definitions for the ROM-based address sequencer.
// Holds the FSM state encoding, the BaseSel codes driven onto the base-register
// mux, the Baseen load-strobe codes and the fixed output widths.
package kcc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_RD    = 3'd3,
    S_WR    = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Base register selected by BaseSel: source base vs destination base
  localparam logic [2:0] RDBASE1 = 3'd0;
  localparam logic [2:0] RDBASE2 = 3'd1;

  // Baseen strobes: which base register latches ROM data this cycle
  localparam logic [1:0] BASEEN_NONE = 2'd0;
  localparam logic [1:0] BASEEN_RD   = 2'd1;
  localparam logic [1:0] BASEEN_WT   = 2'd2;

  localparam int unsigned ROMSEL_W = 4;
  localparam int unsigned RDOFS_W  = 5;
  localparam int unsigned WTOFS_W  = 6;

endpackage

// File: rtl/addr_seq.sv
// Address sequencer: on a start pulse, loads the source and destination base
// registers from ROM, then walks a word index through alternating read/write
// cycles and pulses done at the end.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle command pulse (honoured only in IDLE)
//   rd_sel, wt_sel      ROM base selectors for source / destination
//   nwords              word count, 0 encodes 2^NW_W
//   hold                datapath stall, honoured only in RD/WR
//   ROMBaseSel, Baseen  ROM base lookup and base-register load strobes
//   BaseSel, OffsetSel  base / offset mux selects for the address adder
//   RdOffset, WtOffset  current word offset for read / write
//   rd_en, wt_en        read / write strobes
//   suspend, busy, done status (done is a one-cycle pulse)
// Every output is a register loaded with the decode of the state being
// entered, so outputs line up with the state they belong to.
module addr_seq
  import kcc_pkg::*;
#(
  parameter int unsigned NW_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          rd_sel,
  input  logic [3:0]          wt_sel,
  input  logic [NW_W-1:0]     nwords,
  input  logic                hold,
  output logic [3:0]          ROMBaseSel,
  output logic [1:0]          Baseen,
  output logic [2:0]          BaseSel,
  output logic                OffsetSel,
  output logic                suspend,
  output logic [4:0]          RdOffset,
  output logic [5:0]          WtOffset,
  output logic                rd_en,
  output logic                wt_en,
  output logic                busy,
  output logic                done
);

  state_t            state_q;
  logic [3:0]        wt_sel_q;
  logic [NW_W-1:0]   count_q;
  logic [NW_W-1:0]   idx_q;
  logic [NW_W-1:0]   last_idx;
  logic [NW_W-1:0]   idx_inc;

  // count 0 wraps to all-ones here, giving 2^NW_W words without a wider index
  assign last_idx = count_q - NW_W'(1);
  assign idx_inc  = idx_q + NW_W'(1);

  // Sequencer FSM with registered output decode of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wt_sel_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      ROMBaseSel <= '0;
      Baseen     <= BASEEN_NONE;
      BaseSel    <= RDBASE1;
      OffsetSel  <= 1'b0;
      suspend    <= 1'b0;
      RdOffset   <= '0;
      WtOffset   <= '0;
      rd_en      <= 1'b0;
      wt_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ROMBaseSel <= '0;
      Baseen     <= BASEEN_NONE;
      BaseSel    <= RDBASE1;
      OffsetSel  <= 1'b0;
      RdOffset   <= '0;
      WtOffset   <= '0;
      rd_en      <= 1'b0;
      wt_en      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b1;
      suspend    <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            // rd_sel goes straight into the LOAD1 ROM select register
            wt_sel_q   <= wt_sel;
            count_q    <= nwords;
            state_q    <= S_LOAD1;
            ROMBaseSel <= rd_sel;
            Baseen     <= BASEEN_RD;
          end else begin
            busy    <= 1'b0;
            suspend <= 1'b0;
          end
        end

        S_LOAD1: begin
          state_q    <= S_LOAD2;
          ROMBaseSel <= wt_sel_q;
          Baseen     <= BASEEN_WT;
        end

        S_LOAD2: begin
          idx_q    <= '0;
          state_q  <= S_RD;
          BaseSel  <= RDBASE1;
          RdOffset <= '0;
          rd_en    <= 1'b1;
        end

        S_RD: begin
          if (hold) begin
            // stalled: keep the read address, drop the strobe
            BaseSel  <= RDBASE1;
            RdOffset <= RDOFS_W'(idx_q);
          end else begin
            state_q   <= S_WR;
            BaseSel   <= RDBASE2;
            OffsetSel <= 1'b1;
            WtOffset  <= WTOFS_W'(idx_q);
            wt_en     <= 1'b1;
          end
        end

        S_WR: begin
          if (hold) begin
            BaseSel   <= RDBASE2;
            OffsetSel <= 1'b1;
            WtOffset  <= WTOFS_W'(idx_q);
          end else if (idx_q == last_idx) begin
            state_q <= S_FIN;
            done    <= 1'b1;
          end else begin
            idx_q    <= idx_inc;
            state_q  <= S_RD;
            BaseSel  <= RDBASE1;
            RdOffset <= RDOFS_W'(idx_inc);
            rd_en    <= 1'b1;
          end
        end

        S_FIN: begin
          // start is deliberately ignored on the way back to IDLE
          state_q <= S_IDLE;
          busy    <= 1'b0;
          suspend <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          suspend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq.sv
// Bench for addr_seq: each command is expanded into its list of operations
// (load source base, load destination base, read/write pairs, finish) and the
// DUT outputs are compared every cycle against that list, with hold stretching
// the current read/write step.
module tb_addr_seq;

  localparam int unsigned NW_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      rd_sel;
  logic [3:0]      wt_sel;
  logic [NW_W-1:0] nwords;
  logic            hold;
  logic [3:0]      ROMBaseSel;
  logic [1:0]      Baseen;
  logic [2:0]      BaseSel;
  logic            OffsetSel;
  logic            suspend;
  logic [4:0]      RdOffset;
  logic [5:0]      WtOffset;
  logic            rd_en;
  logic            wt_en;
  logic            busy;
  logic            done;

  logic [25:0]     obs;

  int checks = 0;
  int errors = 0;

  typedef enum int {K_IDLE, K_L1, K_L2, K_RD, K_WR, K_FIN} kind_t;

  addr_seq #(.NW_W(NW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_sel(rd_sel), .wt_sel(wt_sel),
    .nwords(nwords), .hold(hold), .ROMBaseSel(ROMBaseSel), .Baseen(Baseen),
    .BaseSel(BaseSel), .OffsetSel(OffsetSel), .suspend(suspend),
    .RdOffset(RdOffset), .WtOffset(WtOffset), .rd_en(rd_en), .wt_en(wt_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {ROMBaseSel, Baseen, BaseSel, OffsetSel, suspend, RdOffset,
                WtOffset, rd_en, wt_en, busy, done};

  // Expected output vector for one operation of a command
  function automatic logic [25:0] exp_vec(kind_t k, int idx, bit frozen,
                                          logic [3:0] r, logic [3:0] w);
    logic [3:0] rom;
    logic [1:0] be;
    logic [2:0] bs;
    logic       os, sus, re, we, bz, dn;
    logic [4:0] ro;
    logic [5:0] wo;
    rom = '0; be = '0; bs = '0; os = 1'b0; sus = 1'b1; re = 1'b0;
    we = 1'b0; bz = 1'b1; dn = 1'b0; ro = '0; wo = '0;
    case (k)
      K_IDLE: begin sus = 1'b0; bz = 1'b0; end
      K_L1:   begin rom = r; be = 2'd1; end
      K_L2:   begin rom = w; be = 2'd2; end
      K_RD:   begin bs = 3'd0; os = 1'b0; ro = 5'(idx); re = !frozen; end
      K_WR:   begin bs = 3'd1; os = 1'b1; wo = 6'(idx); we = !frozen; end
      K_FIN:  dn = 1'b1;
      default: ;
    endcase
    return {rom, be, bs, os, sus, ro, wo, re, we, bz, dn};
  endfunction

  task automatic check_vec(input string tag, input logic [25:0] o, input logic [25:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o == e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  function automatic bit pick_hold(int c, int pct, int from, int len);
    if (c >= from && c < from + len) return 1'b1;
    if (pct > 0 && $urandom_range(99) < pct) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one command at cycle 0 and follow it cycle by cycle.
  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_cmd(input string name, input logic [3:0] r, input logic [3:0] w,
                         input logic [NW_W-1:0] nw, input int hold_pct,
                         input int hold_from, input int hold_len,
                         input int sp_a, input int sp_b, input int abort_at,
                         input int exp_done);
    kind_t kq[$];
    int    iq[$];
    int    n, ptr, done_cnt, done_at, rd_cnt, wt_cnt;
    bit    frozen, hold_prev, completed, aborted;
    logic [25:0] e;

    n = (nw == '0) ? (1 << NW_W) : int'(nw);
    kq.push_back(K_L1); iq.push_back(0);
    kq.push_back(K_L2); iq.push_back(0);
    for (int k = 0; k < n; k++) begin
      kq.push_back(K_RD); iq.push_back(k);
      kq.push_back(K_WR); iq.push_back(k);
    end
    kq.push_back(K_FIN); iq.push_back(0);

    ptr = -1; frozen = 1'b0; done_cnt = 0; done_at = -1; rd_cnt = 0; wt_cnt = 0;
    completed = 1'b0; aborted = 1'b0;

    start = 1'b1; rd_sel = r; wt_sel = w; nwords = nw;
    hold = pick_hold(0, hold_pct, hold_from, hold_len);
    hold_prev = hold;

    for (int c = 1; c < 400; c++) begin
      @(posedge clk); #1;
      if (ptr < 0) begin
        ptr = 0; frozen = 1'b0;
      end else if ((kq[ptr] == K_RD || kq[ptr] == K_WR) && hold_prev) begin
        frozen = 1'b1;
      end else begin
        ptr++; frozen = 1'b0;
      end
      if (ptr >= kq.size()) e = exp_vec(K_IDLE, 0, 1'b0, r, w);
      else e = exp_vec(kq[ptr], iq[ptr], frozen, r, w);
      check_vec($sformatf("%s cyc%0d", name, c), obs, e);
      if (done) begin done_cnt++; done_at = c; end
      if (rd_en) rd_cnt++;
      if (wt_en) wt_cnt++;
      if (ptr >= kq.size()) begin
        completed = 1'b1;
        break;
      end
      if (c == abort_at) begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        #1;
        check_vec($sformatf("%s abort_now", name), obs, exp_vec(K_IDLE, 0, 1'b0, r, w));
        @(posedge clk); #1;
        check_vec($sformatf("%s abort_held", name), obs, exp_vec(K_IDLE, 0, 1'b0, r, w));
        if (done) done_cnt++;
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      start  = (c == sp_a || c == sp_b);
      rd_sel = 4'($urandom);
      wt_sel = 4'($urandom);
      nwords = NW_W'($urandom);
      hold   = pick_hold(c, hold_pct, hold_from, hold_len);
      hold_prev = hold;
    end

    start = 1'b0; hold = 1'b0;
    if (aborted) begin
      check_int({name, " done_after_abort"}, done_cnt, 0);
      return;
    end
    check_int({name, " completed"}, int'(completed), 1);
    check_int({name, " done_pulses"}, done_cnt, 1);
    check_int({name, " rd_en_count"}, rd_cnt, n);
    check_int({name, " wt_en_count"}, wt_cnt, n);
    if (exp_done >= 0) check_int({name, " done_cycle"}, done_at, exp_done);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    rd_sel = '0; wt_sel = '0; nwords = '0;

    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_state", obs, 26'd0);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_vec($sformatf("idle_before_start%0d", k), obs, 26'd0);
    end

    run_cmd("basic_n4",  4'd3, 4'd5, 5'd4, 0, -1, 0, -1, -1, -1, 11);
    run_cmd("full_n0",   4'd9, 4'd2, 5'd0, 0, -1, 0, -1, -1, -1, 67);
    run_cmd("hold_n3",   4'd1, 4'd14, 5'd3, 0, 6, 3, -1, -1, -1, 12);
    run_cmd("restart_n4", 4'd7, 4'd8, 5'd4, 0, -1, 0, 4, 9, -1, 11);
    run_cmd("start_in_fin", 4'd6, 4'd10, 5'd2, 0, -1, 0, 7, -1, -1, 7);
    run_cmd("abort_n4",  4'd12, 4'd4, 5'd4, 0, -1, 0, -1, -1, 6, -1);
    run_cmd("after_rst_n1", 4'd15, 4'd0, 5'd1, 0, -1, 0, -1, -1, -1, 5);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_vec($sformatf("idle_after_done%0d", k), obs, 26'd0);
    end

    for (int t = 0; t < 8; t++) begin
      run_cmd($sformatf("rand%0d", t), 4'($urandom), 4'($urandom),
              NW_W'($urandom), 30, -1, 0, -1, -1, -1, -1);
      repeat ($urandom_range(2)) @(posedge clk);
      #0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_seq.md
ADDR_SEQ -- requirements
Module: addr_seq

Interface
REQ-001 SHALL have parameter NW_W, default 5, meaning the word-count and offset width (max transfer 2^NW_W words).
REQ-002 SHALL have ports: clk in 1 (system clock); rst in 1 (async reset, active-high); start in 1 (one-cycle command pulse); rd_sel in 4 (ROM base selector, source operand); wt_sel in 4 (ROM base selector, destination operand); nwords in NW_W (word count, 0 encodes 2^NW_W); hold in 1 (stall request from datapath).
REQ-003 SHALL have ports: ROMBaseSel out 4; Baseen out 2; BaseSel out 3; OffsetSel out 1; suspend out 1; RdOffset out 5; WtOffset out 6; rd_en out 1; wt_en out 1; busy out 1; done out 1 (one-cycle completion pulse).
REQ-004 SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-005 SHALL implement states IDLE, LOAD1, LOAD2, RD, WR, FIN.
REQ-006 IDLE: start=1 SHALL capture rd_sel, wt_sel, nwords and go to LOAD1; start=0 stays IDLE.
REQ-007 LOAD1 SHALL drive ROMBaseSel=rd_sel captured, Baseen=1, then go to LOAD2 unconditionally.
REQ-008 LOAD2 SHALL drive ROMBaseSel=wt_sel captured, Baseen=2, clear word index i to 0, then go to RD.
REQ-009 RD SHALL drive BaseSel=0, OffsetSel=0, RdOffset=i, rd_en=1, then go to WR.
REQ-010 WR SHALL drive BaseSel=1, OffsetSel=1, WtOffset={0,i}, wt_en=1; if i==count-1 go to FIN, else i<=i+1 and go to RD.
REQ-011 FIN SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-012 Latency: start at cycle 0 -> LOAD1 cycle 1, first rd_en cycle 3, last wt_en cycle 2+2N, done cycle 3+2N (N = effective count).
REQ-013 nwords=0 SHALL transfer 2^NW_W words; i SHALL never wrap within a command.
REQ-014 hold=1 in RD or WR SHALL freeze state and i, and force rd_en=wt_en=0; addresses held stable; hold ignored in other states.
REQ-015 start while busy SHALL be ignored (no re-capture, no queueing).
REQ-016 busy SHALL be 1 in every state except IDLE; start and done never both honoured in the same cycle (FIN ignores start).
REQ-017 suspend SHALL be 1 in all states except IDLE, where it is 0 (address port returns to scalar offset).
REQ-018 Outside their owning states: Baseen=0, BaseSel=0, OffsetSel=0, ROMBaseSel=0, RdOffset=0, WtOffset=0, rd_en=wt_en=0.
REQ-019 All outputs SHALL be registered-state decodes with no combinational path from start or hold to Baseen/ROMBaseSel.

Reset
REQ-020 rst SHALL force IDLE, i=0, captured selectors and count =0, all outputs to REQ-018 values, busy=0, done=0, suspend=0.
REQ-021 rst asserted mid-transfer SHALL abort immediately with no done pulse; first post-reset start SHALL behave as from power-up.

Structure
REQ-022 State encoding and BaseSel codes (RDBASE1=0, RDBASE2=1) SHALL live in shared package kcc_pkg.
REQ-023 Single module, no sub-modules; index counter in-line.

Verification
REQ-024 start, rd_sel=3, wt_sel=5, nwords=4 -> Baseen 1 then 2 with ROMBaseSel 3,5; rd_en/wt_en alternate RdOffset 0..3, WtOffset 0..3; done at cycle 11.
REQ-025 nwords=0 -> 32 RD/WR pairs, final WtOffset=31, done at cycle 67, i never wraps.
REQ-026 nwords=3, hold=1 for 3 cycles during second WR -> WtOffset=1 held, wt_en=0 while held, done delayed by 3 cycles (cycle 12).
REQ-027 start pulsed again at cycles 4 and 9 of an nwords=4 command -> ignored, single done at cycle 11.
REQ-028 rst at cycle 6 of nwords=4 -> all outputs zero immediately, no done; new start with nwords=1 -> done at cycle 5 after start.
REQ-029 Idle checks: suspend=0, busy=0 before start and after done; nwords=1 -> exactly one rd_en and one wt_en.
